seg_scan_capture: RTL and testbench

//  Receive end of the multiplexed 3-digit 7-segment bus (SEG_C gfe_dcba + active-low SEG_SEL).

---
 rtl/seg_pkg.sv | 30 +++
 rtl/seg_pattern_dec.sv | 28 ++
 rtl/seg_scan_capture.sv | 100 ++++++++++
 tb/tb_seg_scan_capture.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: segment patterns, select codes and helpers shared by the scan capture block.
package seg_pkg;

   localparam int NUM_DIGITS = 3;

   localparam logic [6:0] SEG_0 = 7'h3f;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5b;
   localparam logic [6:0] SEG_3 = 7'h4f;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6d;
   localparam logic [6:0] SEG_6 = 7'h7c;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7f;
   localparam logic [6:0] SEG_9 = 7'h67;
   localparam logic [6:0] SEG_6_ALT = 7'h7d;
   localparam logic [6:0] SEG_7_ALT = 7'h27;
   localparam logic [6:0] SEG_9_ALT = 7'h6f;

   localparam logic [7:0] SEL_ONES = 8'hfe;
   localparam logic [7:0] SEL_TENS = 8'hfd;
   localparam logic [7:0] SEL_HUND = 8'hfb;

   typedef enum logic [1:0] {IDX_ONES, IDX_TENS, IDX_HUND} dig_idx_t;

   function automatic logic [9:0] bcd3_to_bin(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
      return 10'(h) * 10'd100 + 10'(t) * 10'd10 + 10'(o);
   endfunction

endpackage

// File: rtl/seg_pattern_dec.sv
// seg_pattern_dec: reverse-decodes a gfedcba segment pattern to a BCD digit.
module seg_pattern_dec
   import seg_pkg::*;
(
   input  logic [6:0] pat,
   output logic       valid,
   output logic [3:0] digit
);

   always_comb begin
      valid = 1'b1;
      digit = 4'd0;
      case (pat)
         SEG_0:                digit = 4'd0;
         SEG_1:                digit = 4'd1;
         SEG_2:                digit = 4'd2;
         SEG_3:                digit = 4'd3;
         SEG_4:                digit = 4'd4;
         SEG_5:                digit = 4'd5;
         SEG_6, SEG_6_ALT:     digit = 4'd6;
         SEG_7, SEG_7_ALT:     digit = 4'd7;
         SEG_8:                digit = 4'd8;
         SEG_9, SEG_9_ALT:     digit = 4'd9;
         default:              valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: samples a scanned 3-digit 7-segment bus and rebuilds the displayed
// number as BCD digits plus a binary value, flagging bad patterns and a stalled scan.
module seg_scan_capture
   import seg_pkg::*;
#(
   parameter int STABLE_CNT  = 4,
   parameter int TIMEOUT_CNT = 2**20
)(
   input  logic       CLK,
   input  logic       RESET,
   input  logic [6:0] SEG_C,
   input  logic [7:0] SEG_SEL,
   output logic [3:0] DIGIT_1,
   output logic [3:0] DIGIT_10,
   output logic [3:0] DIGIT_100,
   output logic [9:0] VALUE,
   output logic       FRAME_VALID,
   output logic       DIGIT_ERR,
   output logic       STALE
);

   localparam int SW = $clog2(STABLE_CNT + 1);
   localparam int TW = $clog2(TIMEOUT_CNT);

   logic [6:0] seg_s1, seg_s2, seg_p;
   logic [7:0] sel_s1, sel_s2, sel_p;
   logic [SW-1:0] scnt;
   logic [TW-1:0] tcnt;
   logic [NUM_DIGITS-1:0][3:0] shadow;
   logic [NUM_DIGITS-1:0] seen;
   logic same, sel_ok, cap, frame, tmo, dec_valid;
   logic [3:0] dec_digit;
   dig_idx_t idx;

   seg_pattern_dec u_dec (
      .pat   (seg_s2),
      .valid (dec_valid),
      .digit (dec_digit)
   );

   // Capture fires on the sample that brings the run of identical samples to STABLE_CNT;
   // the counter then parks at STABLE_CNT so a held window is captured only once.
   always_comb begin
      same   = {sel_s2, seg_s2} == {sel_p, seg_p};
      sel_ok = sel_s2 == SEL_ONES || sel_s2 == SEL_TENS || sel_s2 == SEL_HUND;
      idx    = sel_s2 == SEL_ONES ? IDX_ONES : sel_s2 == SEL_TENS ? IDX_TENS : IDX_HUND;
      cap    = sel_ok && same && scnt == SW'(STABLE_CNT - 2);
      frame  = &seen;
      tmo    = !cap && tcnt == TW'(TIMEOUT_CNT - 1);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         seg_s1      <= 7'h7f;
         seg_s2      <= 7'h7f;
         seg_p       <= 7'h7f;
         sel_s1      <= 8'hff;
         sel_s2      <= 8'hff;
         sel_p       <= 8'hff;
         scnt        <= '0;
         tcnt        <= '0;
         shadow      <= '0;
         seen        <= '0;
         DIGIT_1     <= '0;
         DIGIT_10    <= '0;
         DIGIT_100   <= '0;
         VALUE       <= '0;
         FRAME_VALID <= 1'b0;
         DIGIT_ERR   <= 1'b0;
         STALE       <= 1'b0;
      end else begin
         seg_s1      <= SEG_C;
         seg_s2      <= seg_s1;
         seg_p       <= seg_s2;
         sel_s1      <= SEG_SEL;
         sel_s2      <= sel_s1;
         sel_p       <= sel_s2;
         scnt        <= (!sel_ok || !same) ? '0 : scnt == SW'(STABLE_CNT) ? scnt : scnt + 1'b1;
         tcnt        <= cap ? '0 : tmo ? tcnt : tcnt + 1'b1;
         DIGIT_ERR   <= cap && !dec_valid;
         FRAME_VALID <= frame;
         if (frame || tmo)
            seen <= '0;
         if (cap)
            seen[idx] <= dec_valid;
         if (cap && dec_valid)
            shadow[idx] <= dec_digit;
         if (tmo)
            STALE <= 1'b1;
         if (frame) begin
            DIGIT_1   <= shadow[IDX_ONES];
            DIGIT_10  <= shadow[IDX_TENS];
            DIGIT_100 <= shadow[IDX_HUND];
            VALUE     <= bcd3_to_bin(shadow[IDX_HUND], shadow[IDX_TENS], shadow[IDX_ONES]);
            STALE     <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: directed vector table plus hand sequences for timeout and reset.
module tb_seg_scan_capture;

   localparam int TMO = 256;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [6:0] SEG_C;
   logic [7:0] SEG_SEL;
   logic [3:0] DIGIT_1, DIGIT_10, DIGIT_100;
   logic [9:0] VALUE;
   logic       FRAME_VALID, DIGIT_ERR, STALE;

   int checks = 0;
   int failures = 0;
   int fv_cnt = 0;
   int err_cnt = 0;
   logic stale_prev = 1'b0, stale_at_fv = 1'b1, stale_before = 1'b0;

   seg_scan_capture #(.STABLE_CNT(4), .TIMEOUT_CNT(TMO)) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .SEG_C       (SEG_C),
      .SEG_SEL     (SEG_SEL),
      .DIGIT_1     (DIGIT_1),
      .DIGIT_10    (DIGIT_10),
      .DIGIT_100   (DIGIT_100),
      .VALUE       (VALUE),
      .FRAME_VALID (FRAME_VALID),
      .DIGIT_ERR   (DIGIT_ERR),
      .STALE       (STALE)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (FRAME_VALID === 1'b1) begin
         stale_at_fv  = STALE;
         stale_before = stale_prev;
      end
      stale_prev = STALE;
      fv_cnt  += (FRAME_VALID === 1'b1) ? 1 : 0;
      err_cnt += (DIGIT_ERR === 1'b1) ? 1 : 0;
   end

   typedef struct {
      logic [6:0] p1, p10, p100;
      int         win, reps, fv, err;
      logic [3:0] d1, d10, d100;
      logic [9:0] val;
   } vec_t;

   vec_t v[7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [7:0] sel, input logic [6:0] seg, input int n);
      SEG_SEL = sel;
      SEG_C   = seg;
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic scan(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c, input int win, input int reps);
      repeat (reps) begin
         drive(8'hfe, a, win);
         drive(8'hfd, b, win);
         drive(8'hfb, c, win);
      end
      drive(8'hff, 7'h7f, 12);
   endtask

   task automatic chk_out(input string nm, input logic [3:0] d1, input logic [3:0] d10, input logic [3:0] d100, input logic [9:0] val);
      chk({nm, ".d1"}, 32'(DIGIT_1), 32'(d1));
      chk({nm, ".d10"}, 32'(DIGIT_10), 32'(d10));
      chk({nm, ".d100"}, 32'(DIGIT_100), 32'(d100));
      chk({nm, ".value"}, 32'(VALUE), 32'(val));
   endtask

   initial begin
      int f0, e0;
      v[0] = '{7'h06, 7'h5b, 7'h4f, 10, 1, 1, 0, 4'd1, 4'd2, 4'd3, 10'd321};
      v[1] = '{7'h7f, 7'h7f, 7'h7f,  3, 4, 0, 0, 4'd1, 4'd2, 4'd3, 10'd321};
      v[2] = '{7'h7f, 7'h7f, 7'h7f,  8, 1, 1, 0, 4'd8, 4'd8, 4'd8, 10'd888};
      v[3] = '{7'h7d, 7'h27, 7'h6f,  8, 1, 1, 0, 4'd6, 4'd7, 4'd9, 10'd976};
      v[4] = '{7'h67, 7'h6f, 7'h67,  8, 1, 1, 0, 4'd9, 4'd9, 4'd9, 10'd999};
      v[5] = '{7'h3f, 7'h3f, 7'h3f,  8, 1, 1, 0, 4'd0, 4'd0, 4'd0, 10'd0};
      v[6] = '{7'h06, 7'h55, 7'h4f,  8, 1, 0, 1, 4'd0, 4'd0, 4'd0, 10'd0};
      RESET   = 1'b1;
      SEG_SEL = 8'hff;
      SEG_C   = 7'h7f;
      repeat (3) @(posedge CLK);
      #1 RESET = 1'b0;
      chk_out("reset", 4'd0, 4'd0, 4'd0, 10'd0);
      chk("reset.frame_valid", 32'(FRAME_VALID), 0);
      chk("reset.digit_err", 32'(DIGIT_ERR), 0);
      chk("reset.stale", 32'(STALE), 0);
      for (int i = 0; i < 7; i++) begin
         f0 = fv_cnt;
         e0 = err_cnt;
         scan(v[i].p1, v[i].p10, v[i].p100, v[i].win, v[i].reps);
         chk($sformatf("vec%0d.frames", i), 32'(fv_cnt - f0), 32'(v[i].fv));
         chk($sformatf("vec%0d.errs", i), 32'(err_cnt - e0), 32'(v[i].err));
         chk_out($sformatf("vec%0d", i), v[i].d1, v[i].d10, v[i].d100, v[i].val);
      end
      // ones=1 and hundreds=3 survive the bad tens window; a lone valid tens completes the frame
      f0 = fv_cnt;
      drive(8'hfd, 7'h5b, 8);
      drive(8'hff, 7'h7f, 12);
      chk("retens.frames", 32'(fv_cnt - f0), 1);
      chk_out("retens", 4'd1, 4'd2, 4'd3, 10'd321);
      // timeout: a lone ones capture is discarded once STALE asserts
      drive(8'hfe, 7'h3f, 8);
      drive(8'hff, 7'h7f, 200);
      chk("pre_timeout.stale", 32'(STALE), 0);
      drive(8'hff, 7'h7f, 80);
      chk("timeout.stale", 32'(STALE), 1);
      chk_out("timeout.hold", 4'd1, 4'd2, 4'd3, 10'd321);
      f0 = fv_cnt;
      drive(8'hfd, 7'h5b, 8);
      drive(8'hfb, 7'h4f, 8);
      drive(8'hff, 7'h7f, 12);
      chk("timeout.seen_cleared", 32'(fv_cnt - f0), 0);
      chk("timeout.stale_held", 32'(STALE), 1);
      f0 = fv_cnt;
      drive(8'hfe, 7'h7f, 8);
      drive(8'hff, 7'h7f, 12);
      chk("recover.frames", 32'(fv_cnt - f0), 1);
      chk("recover.stale_at_fv", 32'(stale_at_fv), 0);
      chk("recover.stale_before_fv", 32'(stale_before), 1);
      chk_out("recover", 4'd8, 4'd2, 4'd3, 10'd328);
      drive(8'hff, 7'h7f, TMO + 40);
      chk("retimeout.stale", 32'(STALE), 1);
      // reset mid-frame clears outputs, seen and shadow asynchronously
      drive(8'hfe, 7'h06, 8);
      drive(8'hfd, 7'h5b, 8);
      drive(8'hff, 7'h7f, 4);
      RESET = 1'b1;
      #2;
      chk_out("midreset", 4'd0, 4'd0, 4'd0, 10'd0);
      chk("midreset.stale", 32'(STALE), 0);
      @(posedge CLK);
      #1 RESET = 1'b0;
      f0 = fv_cnt;
      drive(8'hfb, 7'h4f, 8);
      drive(8'hff, 7'h7f, 12);
      chk("postreset.lone_hund", 32'(fv_cnt - f0), 0);
      chk_out("postreset", 4'd0, 4'd0, 4'd0, 10'd0);
      f0 = fv_cnt;
      drive(8'hfe, 7'h06, 8);
      drive(8'hfd, 7'h5b, 8);
      drive(8'hff, 7'h7f, 12);
      chk("postreset.frames", 32'(fv_cnt - f0), 1);
      chk_out("postreset.frame", 4'd1, 4'd2, 4'd3, 10'd321);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
